// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR driven by an externally supplied tap mask.
// Streams the register MSB one bit per valid/ready handshake, counts steps
// since the last seed load, flags the all-zero lock state and measures the
// sequence period as the number of steps taken to come back to the seed.
module lfsr_core #(
    parameter int REG_SIZE = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_SIZE-1:0] taps,
    input  logic [REG_SIZE-1:0] seed,
    input  logic                seed_load,
    input  logic                enable,
    input  logic                out_ready,
    output logic                out_bit,
    output logic                out_valid,
    output logic [REG_SIZE-1:0] state,
    output logic                lockup,
    output logic [CNT_W-1:0]    step_count,
    output logic [CNT_W-1:0]    period,
    output logic                period_hit
);

    // IDLE: nothing loaded yet; RUN: stepping allowed; LOCK: stuck at zero.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } fsm_t;

    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [REG_SIZE-1:0] STATE_ZERO = '0;

    fsm_t                fsm;
    logic [REG_SIZE-1:0] seed_copy;
    logic [REG_SIZE-1:0] next_state;
    logic                feedback;
    logic                step;
    logic [CNT_W-1:0]    step_count_inc;

    // Feedback, next register value and handshake qualification.
    // NOTE: every signal driven here gets a value on every path (no if without
    // else), so no latch can be inferred.
    always_comb begin
        feedback       = ^(state & taps);
        next_state     = {state[REG_SIZE-2:0], feedback};
        step_count_inc = step_count + CNT_ONE;
        step           = (fsm == RUN) && enable && out_ready && !seed_load;
    end

    // Stream outputs: the bit offered is always the current MSB.
    always_comb begin
        out_bit   = state[REG_SIZE-1];
        out_valid = (fsm == RUN) && enable;
        lockup    = (fsm == LOCK);
    end

    // LFSR register, seed copy, counters and control FSM.
    // NOTE: non-blocking assignments throughout, so every right-hand side sees
    // the pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm        <= IDLE;
            state      <= '0;
            seed_copy  <= '0;
            step_count <= '0;
            period     <= '0;
            period_hit <= 1'b0;
        end else if (seed_load) begin
            // A seed load wins over a simultaneous handshake; that step is lost.
            state      <= seed;
            seed_copy  <= seed;
            step_count <= '0;
            period_hit <= 1'b0;
            fsm        <= (seed != STATE_ZERO) ? RUN : LOCK;
        end else if (step) begin
            state      <= next_state;
            step_count <= step_count_inc;
            if (next_state == seed_copy) begin
                // Counter keeps running; period captures the step that closed the loop.
                period     <= step_count_inc;
                period_hit <= 1'b1;
            end else begin
                period_hit <= 1'b0;
            end
            if (next_state == STATE_ZERO) begin
                fsm <= LOCK;
            end
        end else begin
            period_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_core.sv
// Testbench for lfsr_core: directed scenarios followed by a randomized run,
// all compared against a behavioural model built from plain integer arithmetic.
module tb_lfsr_core;

    localparam int REG_SIZE = 8;
    localparam int CNT_W    = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [REG_SIZE-1:0] taps;
    logic [REG_SIZE-1:0] seed;
    logic                seed_load;
    logic                enable;
    logic                out_ready;
    logic                out_bit;
    logic                out_valid;
    logic [REG_SIZE-1:0] state;
    logic                lockup;
    logic [CNT_W-1:0]    step_count;
    logic [CNT_W-1:0]    period;
    logic                period_hit;

    lfsr_core #(.REG_SIZE(REG_SIZE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .taps       (taps),
        .seed       (seed),
        .seed_load  (seed_load),
        .enable     (enable),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .state      (state),
        .lockup     (lockup),
        .step_count (step_count),
        .period     (period),
        .period_hit (period_hit)
    );

    always #5 clk = ~clk;

    int n_asserts  = 0;
    int n_failures = 0;

    // Reference model: integers and two flags, derived from the behavioural rules.
    int m_state, m_seed, m_cnt, m_period;
    bit m_hit, m_loaded, m_locked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_seed = 0; m_cnt = 0; m_period = 0;
        m_hit = 0; m_loaded = 0; m_locked = 0;
    endtask

    // Apply what the coming rising edge should do given the present inputs.
    task automatic model_edge();
        int nxt;
        if (!reset) begin
            model_reset();
        end else if (seed_load) begin
            m_state  = int'(seed);
            m_seed   = int'(seed);
            m_cnt    = 0;
            m_hit    = 0;
            m_loaded = 1;
            m_locked = (seed == 0);
        end else if (m_loaded && !m_locked && enable && out_ready) begin
            nxt     = (m_state * 2 + ($countones(m_state & int'(taps)) % 2)) % 256;
            m_state = nxt;
            m_cnt   = (m_cnt + 1) % 65536;
            m_hit   = (nxt == m_seed);
            if (m_hit) m_period = m_cnt;
            if (nxt == 0) m_locked = 1;
        end else begin
            m_hit = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},      32'(state),      32'(m_state));
        check({tag, ".out_bit"},    32'(out_bit),    32'(m_state >= 128));
        check({tag, ".out_valid"},  32'(out_valid),  32'(m_loaded && !m_locked && enable));
        check({tag, ".lockup"},     32'(lockup),     32'(m_locked));
        check({tag, ".step_count"}, 32'(step_count), 32'(m_cnt));
        check({tag, ".period"},     32'(period),     32'(m_period));
        check({tag, ".period_hit"}, 32'(period_hit), 32'(m_hit));
    endtask

    // One clock: predict, let the edge happen, sample 1 ns later.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [7:0] s, input string tag);
        seed = s; seed_load = 1'b1;
        tick(tag);
        seed_load = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_bits;
        int         hits;
        int         budget;

        reset = 1'b0; taps = '0; seed = '0; seed_load = 1'b0;
        enable = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1. Run briefly, then assert reset between edges.
        taps = 8'h8E; enable = 1'b1; out_ready = 1'b1;
        tick("idle");
        check("idle.out_valid_const", 32'(out_valid), 32'd0);
        load(8'h01, "rst.load");
        for (int i = 0; i < 5; i++) tick("rst.run");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("rst.async");
        check("rst.async.state_const", 32'(state), 32'd0);
        tick("rst.hold");
        reset = 1'b1;
        tick("rst.released");
        tick("rst.idle2");
        check("rst.idle.out_valid_const", 32'(out_valid), 32'd0);

        // 2. Rotate: the single set bit walks up to the MSB and back.
        taps = 8'h80;
        load(8'h01, "rot.load");
        exp_bits = 8'b1000_0000;  // consumed bits in order, index 0 first
        for (int i = 0; i < 8; i++) begin
            check("rot.consumed_bit", 32'(out_bit), 32'(exp_bits[i]));
            tick("rot.step");
            if (i == 6) check("rot.state_after7", 32'(state), 32'h80);
        end
        check("rot.state_after8", 32'(state), 32'h01);
        check("rot.period", 32'(period), 32'd8);
        check("rot.step_count", 32'(step_count), 32'd8);
        check("rot.period_hit", 32'(period_hit), 32'd1);
        tick("rot.after");
        check("rot.hit_one_cycle", 32'(period_hit), 32'd0);

        // 3. Maximal-length mask: first return to the seed after 255 steps.
        taps = 8'h8E;
        load(8'h01, "max.load");
        hits = 0;
        budget = 0;
        while (hits == 0 && budget < 300) begin
            tick("max.step");
            budget++;
            if (period_hit) hits++;
            if (state == 0 || lockup) check("max.never_zero", 32'(state), 32'hFFFF);
        end
        check("max.steps_to_hit", 32'(budget), 32'd255);
        check("max.period", 32'(period), 32'd255);

        // 4. Backpressure with ready pattern 1,0,0,1, then enable low.
        taps = 8'h80;
        load(8'h01, "bp.load");
        out_ready = 1'b1; tick("bp.r1");
        check("bp.state1", 32'(state), 32'h02);
        out_ready = 1'b0; tick("bp.r0a");
        check("bp.valid_held", 32'(out_valid), 32'd1);
        tick("bp.r0b");
        check("bp.state_held", 32'(state), 32'h02);
        out_ready = 1'b1; tick("bp.r1b");
        check("bp.state2", 32'(state), 32'h04);
        check("bp.count", 32'(step_count), 32'd2);
        enable = 1'b0; tick("bp.dis");
        check("bp.dis.valid", 32'(out_valid), 32'd0);
        check("bp.dis.state", 32'(state), 32'h04);
        enable = 1'b1;

        // 5. Lockup: zero seed, zero taps drain, recovery by nonzero seed.
        load(8'h00, "lk.zero_seed");
        check("lk.zero.lockup", 32'(lockup), 32'd1);
        check("lk.zero.valid", 32'(out_valid), 32'd0);
        taps = 8'h00;
        load(8'h01, "lk.load1");
        for (int i = 0; i < 8; i++) tick("lk.drain");
        check("lk.drain.state", 32'(state), 32'd0);
        check("lk.drain.lockup", 32'(lockup), 32'd1);
        for (int i = 0; i < 3; i++) tick("lk.ignore_ready");
        check("lk.ignored.count", 32'(step_count), 32'd8);
        taps = 8'h8E;
        load(8'h5A, "lk.recover");
        check("lk.recover.lockup", 32'(lockup), 32'd0);
        check("lk.recover.valid", 32'(out_valid), 32'd1);
        check("lk.recover.state", 32'(state), 32'h5A);

        // 6. Seed load colliding with a handshake.
        for (int i = 0; i < 4; i++) tick("sim.run");
        out_ready = 1'b1;
        load(8'h33, "sim.load");
        check("sim.state", 32'(state), 32'h33);
        check("sim.count", 32'(step_count), 32'd0);

        // Randomized traffic: ready/enable noise, occasional seeds and mask changes.
        for (int i = 0; i < 2000; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            enable    = 1'($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) taps = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                seed = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                seed_load = 1'b1;
            end
            tick("rand");
            seed_load = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule

// File: doc/lfsr_core.md
Name: lfsr_core

Overview:
- Downstream consumer of the serially loaded tap register.
- Takes the parallel tap mask and runs a Fibonacci LFSR from a loaded seed.
- Streams one output bit per accepted valid/ready handshake.
- Tracks steps since seed, detects all-zero lockup, and measures sequence period (return to seed).

Parameters:
- REG_SIZE, 8, LFSR width; must match the tap register width.
- CNT_W, 16, width of the step counter and the period register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- taps  input  REG_SIZE  feedback mask from tap register; sampled every step.
- seed  input  REG_SIZE  initial state value.
- seed_load  input  1  load seed into state (single-cycle strobe or level).
- enable  input  1  gates stepping and output valid.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_bit  output  1  current output bit = state[REG_SIZE-1].
- out_valid  output  1  out_bit is valid.
- state  output  REG_SIZE  current LFSR register.
- lockup  output  1  LFSR is in the all-zero lock state.
- step_count  output  CNT_W  steps since last seed load.
- period  output  CNT_W  latched step count at last return to seed.
- period_hit  output  1  one-cycle pulse when state returns to seed.

Behaviour:
- Reset (reset=0, async): state=0, step_count=0, period=0, period_hit=0, seed register=0, FSM=IDLE.
  - Outputs during/after reset: out_valid=0, lockup=0.
  - Reset asserted mid-sequence aborts immediately.
- FSM states: IDLE, RUN, LOCK.
  - IDLE: no valid seed loaded yet; out_valid=0, lockup=0.
  - RUN: out_valid = enable (combinational).
  - LOCK: out_valid=0, lockup=1.
- Seed load (seed_load=1 at edge, any FSM state):
  - state <= seed; internal seed copy <= seed; step_count <= 0; period_hit <= 0.
  - Next FSM = RUN if seed != 0, else LOCK.
  - seed_load has priority over a simultaneous step; the step is discarded and that handshake does not count.
- Step: occurs at an edge where FSM=RUN, enable=1, out_ready=1, seed_load=0.
  - fb = XOR-reduce(state & taps).
  - state <= {state[REG_SIZE-2:0], fb}.
  - step_count <= step_count+1, wrapping modulo 2^CNT_W.
- Output latency:
  - out_bit is combinational from the state register.
  - The bit consumed in a handshake is the pre-step MSB.
  - The next bit is visible the cycle after the step.
- out_valid=1 with out_ready=0 (or enable=0): hold state, out_bit and step_count unchanged.
- Period detect: on a step whose next state equals the seed copy:
  - period <= step_count+1; period_hit=1 for the following cycle only.
  - step_count continues counting; it is not cleared.
- Lockup:
  - On a step whose next state is 0, FSM <= LOCK (state becomes 0).
  - LOCK exits only via reset or a seed_load with a nonzero seed.
  - LOCK ignores out_ready.
- taps=0:
  - Any nonzero seed shifts to 0 within REG_SIZE steps, then LOCK.
  - This is not an error beyond lockup.
- taps changing mid-run: the new mask is used from the next step; no reset of state.
- After seed_load, period holds its old value until the next period_hit.

Test Plan:
1. Reset mid-run: assert reset=0 asynchronously between edges -> state=0, out_valid=0, lockup=0, step_count=0, period=0 immediately; after release, FSM=IDLE with out_valid=0 until seed_load.
2. Rotate: taps=8'h80, seed=8'h01, enable=1, out_ready=1.
   - out_bit sequence 0,0,0,0,0,0,0,1.
   - After 7 steps state=8'h80.
   - After 8 steps state=8'h01, period_hit pulses once, period=8, step_count=8.
3. Maximal: taps=8'h8E, seed=8'h01, out_ready=1 continuous.
   - First period_hit after exactly 255 steps, period=255.
   - state never 0, lockup stays 0.
4. Backpressure: taps=8'h80, seed=8'h01; toggle out_ready 1,0,0,1.
   - state/step_count advance only on the two ready cycles (state 8'h01->8'h02->8'h04).
   - out_valid stays 1 throughout.
   - enable=0 -> out_valid=0 and no advance.
5. Lockup:
   - seed=0 load -> lockup=1, out_valid=0.
   - taps=0 with seed=8'h01: after 8 steps state=0, lockup=1.
   - Subsequent out_ready ignored.
   - seed_load with seed=8'h5A -> lockup=0, out_valid=1, state=8'h5A.
6. Simultaneous seed_load+handshake: while running, seed_load=1 with seed=8'h33 and out_ready=1 in the same cycle -> state=8'h33, step_count=0, no step applied.
